// File: rtl/trivium_stream_if.sv
// Trivium keystream generator bus: key/IV load and control inputs, status, and the
// valid/ready keystream output. The generator takes the master side.
interface trivium_stream_if #(
    parameter int W = 1
);
    logic         en;
    logic         load;
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         busy;
    logic         warm_up_complete;
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;

    modport master (
        input  en, load, key, iv, ks_ready,
        output busy, warm_up_complete, ks_valid, ks_data
    );

    modport slave (
        output en, load, key, iv, ks_ready,
        input  busy, warm_up_complete, ks_valid, ks_data
    );
endinterface

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator: W unrolled bit updates per clock, runtime key/IV load,
// valid/ready output. Optional accepted-word counter on ks_count via TRIVIUM_WORD_CNT_EN.
module trivium_stream_gen #(
    parameter int W         = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    trivium_stream_if.master     bus
`ifdef TRIVIUM_WORD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] ks_count
`endif
);
    localparam int WARM_WORDS = 1152 / W;

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
        $error("trivium_stream_gen: W=%0d is not one of 1,2,4,8,16,32,64", W);
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("trivium_stream_gen: CNT_WIDTH=%0d must be at least 1", CNT_WIDTH);
    end

    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;

    state_t       state;
    logic [287:0] st_p0;      // st_p0[i-1] holds Trivium state bit s(i)
    logic [287:0] st_adv;
    logic [288:0] step_r;
    logic [W-1:0] z_word;
    logic [10:0]  warm_cnt;
    logic [W-1:0] ks_data_p0;
    logic         vld_p0;
    logic         busy_r;
    logic         warm_r;
    logic         xfer;

    // One Trivium bit update; returns {z, next state}.
    function automatic logic [288:0] step_bit(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    always_comb begin
        st_adv = st_p0;
        z_word = '0;
        step_r = '0;
        for (int k = 0; k < W; k++) begin
            step_r    = step_bit(st_adv);
            z_word[k] = step_r[288];
            st_adv    = step_r[287:0];
        end
    end

    assign xfer = vld_p0 & bus.ks_ready;

    // LOAD always performs the first warm-up step, so WARMUP runs WARM_WORDS more
    // steps and the step that hits a zero count yields the first keystream word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            st_p0      <= '0;
            warm_cnt   <= '0;
            ks_data_p0 <= '0;
            vld_p0     <= 1'b0;
            busy_r     <= 1'b0;
            warm_r     <= 1'b0;
        end else if (bus.load) begin
            st_p0    <= {3'b111, 112'b0, bus.iv, 13'b0, bus.key};
            warm_cnt <= 11'(WARM_WORDS);
            state    <= LOAD;
            vld_p0   <= 1'b0;
            busy_r   <= 1'b1;
            warm_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    st_p0    <= st_adv;
                    warm_cnt <= warm_cnt - 11'd1;
                    state    <= WARMUP;
                end
                WARMUP: begin
                    if (bus.en) begin
                        st_p0 <= st_adv;
                        if (warm_cnt == 11'd0) begin
                            ks_data_p0 <= z_word;
                            vld_p0     <= 1'b1;
                            busy_r     <= 1'b0;
                            warm_r     <= 1'b1;
                            state      <= RUN;
                        end else begin
                            warm_cnt <= warm_cnt - 11'd1;
                        end
                    end
                end
                RUN: begin
                    // Output slot frees when empty or being accepted this cycle.
                    if (!vld_p0 || xfer) begin
                        if (bus.en) begin
                            st_p0      <= st_adv;
                            ks_data_p0 <= z_word;
                            vld_p0     <= 1'b1;
                        end else begin
                            vld_p0 <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRIVIUM_WORD_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ks_count <= '0;
        else if (bus.load)
            ks_count <= '0;
        else if (xfer)
            ks_count <= ks_count + CNT_WIDTH'(1);
    end
`endif

    assign bus.ks_data          = ks_data_p0;
    assign bus.ks_valid         = vld_p0;
    assign bus.busy             = busy_r;
    assign bus.warm_up_complete = warm_r;
endmodule
